// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and data ports: data wins, fetch forced after STARVE_MAX denials.
// Grants are combinational; read data returns 1 cycle after grant to the owning port (no bubble between reads).
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            stall_if,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_n;
  logic       killed_q, killed_n;
  logic [3:0] starve_cnt, starve_n;
  logic       starve;
  logic       unused_if_addr;

  // Fetches are always word reads, so the byte offset is dropped.
  assign unused_if_addr = ^if_addr[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      killed_q   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      killed_q   <= killed_n;
      starve_cnt <= starve_n;
    end
  end

  always_comb begin
    starve    = (starve_cnt == STARVE_LIM);
    d_gnt     = d_req & ~(starve & if_req & ~if_flush);
    if_gnt    = if_req & ~if_flush & ~d_gnt;
    stall_if  = if_req & ~if_gnt;

    mem_en    = d_gnt | if_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_be    = '1;
      mem_addr  = {if_addr[AW-1:2], 2'b00};
    end

    // State names the port owning the read that returns next cycle.
    state_n = IDLE;
    if (if_gnt) begin
      state_n = RESP_IF;
    end else if (d_gnt & ~d_we) begin
      state_n = RESP_D;
    end
    killed_n = if_flush & (state_n == RESP_IF);

    starve_n = starve_cnt;
    if (if_gnt | ~if_req) begin
      starve_n = '0;
    end else if (~if_flush & (starve_cnt != STARVE_LIM)) begin
      starve_n = starve_cnt + 4'd1;
    end

    if_rvalid = (state == RESP_IF) & ~killed_q;
    d_rvalid  = (state == RESP_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table/sequences plus randomized traffic against a port-level model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, stall_if, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM seen by the DUT
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  // Reference model state: who owes which port a read, and the expected memory contents.
  logic [31:0] shadow [256];
  int          m_starve;
  bit          m_if_pend, m_d_pend, m_last_dg, m_last_ig;
  logic [31:0] m_if_dat, m_d_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_starve  = 0;
    m_if_pend = 0;
    m_d_pend  = 0;
    m_last_dg = 0;
    m_last_ig = 0;
  endtask

  task automatic model_check();
    bit fetch_live, take_if, take_d;
    logic [7:0] ii, di;
    fetch_live = if_req && !if_flush;
    take_if    = fetch_live && (m_starve >= STARVE_MAX || !d_req);
    take_d     = d_req && !take_if;
    ii = if_addr[9:2];
    di = d_addr[9:2];

    chk("m_d_gnt", {31'd0, d_gnt}, {31'd0, take_d});
    chk("m_if_gnt", {31'd0, if_gnt}, {31'd0, take_if});
    chk("m_stall", {31'd0, stall_if}, {31'd0, if_req && !take_if});
    chk("m_mem_en", {31'd0, mem_en}, {31'd0, take_d || take_if});
    chk("m_mem_we", {31'd0, mem_we}, {31'd0, take_d && d_we});
    if (take_d) begin
      chk("m_mem_be", {28'd0, mem_be}, {28'd0, d_be});
      chk("m_mem_addr", mem_addr, d_addr);
      chk("m_mem_wdata", mem_wdata, d_wdata);
    end else if (take_if) begin
      chk("m_mem_be", {28'd0, mem_be}, 32'hF);
      chk("m_mem_addr", mem_addr, {22'd0, ii, 2'b00});
    end else begin
      chk("m_mem_be", {28'd0, mem_be}, 32'd0);
      chk("m_mem_addr", mem_addr, 32'd0);
      chk("m_mem_wdata", mem_wdata, 32'd0);
    end
    chk("m_if_rvalid", {31'd0, if_rvalid}, {31'd0, m_if_pend});
    chk("m_if_rdata", if_rdata, m_if_pend ? m_if_dat : 32'd0);
    chk("m_d_rvalid", {31'd0, d_rvalid}, {31'd0, m_d_pend});
    chk("m_d_rdata", d_rdata, m_d_pend ? m_d_dat : 32'd0);

    // advance to next cycle
    if (take_if || !if_req) m_starve = 0;
    else if (!if_flush && m_starve < STARVE_MAX) m_starve++;
    m_if_pend = take_if;
    m_if_dat  = shadow[ii];
    m_d_pend  = take_d && !d_we;
    m_d_dat   = shadow[di];
    if (take_d && d_we)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) shadow[di][8*b +: 8] = d_wdata[8*b +: 8];
    m_last_dg = take_d;
    m_last_ig = take_if;
  endtask

  task automatic drive(input logic ir, input logic fl, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] dwd);
    if_req = ir; if_flush = fl; if_addr = ia;
    d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = dwd;
  endtask

  // One clock: inputs change just after the rising edge, checks on the falling edge.
  task automatic cyc(input logic ir, input logic fl, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] be,
                     input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk);
    #1 drive(ir, fl, ia, dr, dw, be, da, dwd);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic ir, fl, dr, dw;
    logic e_dg, e_ig, e_stall, e_drv, e_irv;
  } vec_t;

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'hC0DE_0000 | i;
      shadow[i] = 32'hC0DE_0000 | i;
    end
    mem_rdata = '0;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Back-to-back fetches
    cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("f1_gnt0", {31'd0, if_gnt}, 32'd1);
    cyc(1, 0, 32'h4, 0, 0, 0, 0, 0);
    chk("f1_gnt1", {31'd0, if_gnt}, 32'd1);
    chk("f1_data0", if_rdata, 32'hC0DE_0000);
    cyc(1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("f1_data1", if_rdata, 32'hC0DE_0001);
    cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("f1_data2", if_rdata, 32'hC0DE_0002);
    cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("f1_idle_rv", {31'd0, if_rvalid}, 32'd0);

    // Conflict, starvation, flush and write, one row per cycle from a zero counter
    tbl[0] = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 0, 1, 1, 0};
    tbl[2] = '{1, 0, 1, 0, 1, 0, 1, 1, 0};
    tbl[3] = '{1, 0, 1, 0, 1, 0, 1, 1, 0};
    tbl[4] = '{1, 0, 1, 0, 0, 1, 0, 1, 0};
    tbl[5] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    tbl[6] = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].ir, tbl[i].fl, 32'h10, tbl[i].dr, tbl[i].dw, 4'hF,
          tbl[i].dw ? 32'h300 : 32'h100, 32'hDEAD_BEEF);
      chk($sformatf("tbl%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, tbl[i].e_dg});
      chk($sformatf("tbl%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, tbl[i].e_ig});
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall_if}, {31'd0, tbl[i].e_stall});
      chk($sformatf("tbl%0d_d_rv", i), {31'd0, d_rvalid}, {31'd0, tbl[i].e_drv});
      chk($sformatf("tbl%0d_if_rv", i), {31'd0, if_rvalid}, {31'd0, tbl[i].e_irv});
    end

    // Partial write then readback
    cyc(0, 0, 0, 1, 1, 4'b0011, 32'h200, 32'hA5A5_1234);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_be", {28'd0, mem_be}, 32'h3);
    chk("wr_mem_addr", mem_addr, 32'h200);
    chk("wr_mem_wdata", mem_wdata, 32'hA5A5_1234);
    cyc(0, 0, 0, 1, 0, 4'hF, 32'h200, 0);
    chk("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_readback", d_rdata, 32'hC0DE_1234);

    // Flush following a granted fetch
    cyc(1, 0, 32'h20, 0, 0, 0, 0, 0);
    chk("fl_gnt_t", {31'd0, if_gnt}, 32'd1);
    cyc(1, 1, 32'h40, 0, 0, 0, 0, 0);
    chk("fl_rv_t1", {31'd0, if_rvalid}, 32'd1);
    chk("fl_gnt_t1", {31'd0, if_gnt}, 32'd0);
    cyc(1, 0, 32'h40, 0, 0, 0, 0, 0);
    chk("fl_rv_t2", {31'd0, if_rvalid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with a data read in flight and a partly built starve count
    repeat (3) cyc(1, 0, 32'h10, 1, 0, 4'hF, 32'h100, 0);
    @(posedge clk);
    #1 rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_mid_d_rv", {31'd0, d_rvalid}, 32'd0);
    chk("rst_mid_d_rdata", d_rdata, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_rel_d_rv", {31'd0, d_rvalid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h10, 1, 0, 4'hF, 32'h104, 0);
      chk($sformatf("rst_starve%0d", i), {31'd0, if_gnt}, {31'd0, i == 4});
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; requests are held until the model says they were granted
    for (int n = 0; n < 1500; n++) begin
      logic        ir, fl, dr, dw;
      logic [31:0] ia, da, dwd;
      logic [3:0]  be;
      ir = if_req; ia = if_addr;
      dr = d_req; dw = d_we; be = d_be; da = d_addr; dwd = d_wdata;
      if (!(if_req && !m_last_ig)) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = $urandom_range(0, 1023);
      end
      fl = ($urandom_range(0, 7) == 0);
      if (!(d_req && !m_last_dg)) begin
        dr  = ($urandom_range(0, 2) != 0);
        dw  = $urandom_range(0, 1);
        be  = 4'($urandom_range(0, 15));
        da  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dwd = $urandom;
      end
      cyc(ir, fl, ia, dr, dw, be, da, dwd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
